// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point-arithmetic datapaths: widths, the
// doubling microprogram encoding and the control-FSM state type.
package ecc_pkg;

  localparam int unsigned WIDTH_DEF = 256;
  localparam int unsigned NSTEPS    = 23;
  localparam logic [4:0]  LAST_STEP = 5'(NSTEPS - 1);

  typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB} op_e;

  typedef enum logic [4:0] {
    R_X, R_Y, R_Z, R_A,
    R_T1, R_T2, R_T3, R_T4, R_T5, R_T6, R_T7, R_T8,
    R_M, R_S, R_X3, R_Y3, R_Z3
  } reg_e;

  localparam int unsigned NREGS = 17;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

  typedef struct packed {
    op_e  op;
    reg_e dst;
    reg_e sa;
    reg_e sb;
  } uop_t;

  // Jacobian doubling: dst = sa (op) sb, one entry per step.
  function automatic uop_t get_uop(input logic [4:0] step);
    uop_t u;
    u = '{OP_ADD, R_T1, R_T1, R_T1};
    case (step)
      5'd0:  u = '{OP_MUL, R_T1, R_X,  R_X };
      5'd1:  u = '{OP_MUL, R_T2, R_Z,  R_Z };
      5'd2:  u = '{OP_MUL, R_T2, R_T2, R_T2};
      5'd3:  u = '{OP_MUL, R_T2, R_A,  R_T2};
      5'd4:  u = '{OP_ADD, R_T3, R_T1, R_T1};
      5'd5:  u = '{OP_ADD, R_T3, R_T3, R_T1};
      5'd6:  u = '{OP_ADD, R_M,  R_T3, R_T2};
      5'd7:  u = '{OP_MUL, R_T4, R_Y,  R_Y };
      5'd8:  u = '{OP_MUL, R_T5, R_X,  R_T4};
      5'd9:  u = '{OP_ADD, R_T5, R_T5, R_T5};
      5'd10: u = '{OP_ADD, R_S,  R_T5, R_T5};
      5'd11: u = '{OP_MUL, R_T6, R_M,  R_M };
      5'd12: u = '{OP_SUB, R_T6, R_T6, R_S };
      5'd13: u = '{OP_SUB, R_X3, R_T6, R_S };
      5'd14: u = '{OP_MUL, R_T7, R_T4, R_T4};
      5'd15: u = '{OP_ADD, R_T7, R_T7, R_T7};
      5'd16: u = '{OP_ADD, R_T7, R_T7, R_T7};
      5'd17: u = '{OP_ADD, R_T7, R_T7, R_T7};
      5'd18: u = '{OP_SUB, R_T8, R_S,  R_X3};
      5'd19: u = '{OP_MUL, R_T8, R_M,  R_T8};
      5'd20: u = '{OP_SUB, R_Y3, R_T8, R_T7};
      5'd21: u = '{OP_MUL, R_Z3, R_Y,  R_Z };
      5'd22: u = '{OP_ADD, R_Z3, R_Z3, R_Z3};
      default: ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Bit-serial MSB-first interleaved modular multiplier, r = a*b mod p.
// done pulses exactly WIDTH+1 cycles after start; r holds until the next start.
module mod_mul
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [WIDTH+1:0] t0, t1;
  logic [CW-1:0]    cnt_q;
  logic             run_q, done_q;

  // acc < p < 2^(WIDTH-1), so 2*acc + a < 3p and two conditional subtractions reduce fully.
  always_comb begin
    t0 = (acc_q << 1) + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    t1 = (t0 >= {2'b00, p_q}) ? t0 - {2'b00, p_q} : t0;
    acc_d = (t1 >= {2'b00, p_q}) ? t1 - {2'b00, p_q} : t1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      p_q    <= p;
      acc_q  <= '0;
      cnt_q  <= CW'(WIDTH);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      acc_q  <= acc_d;
      b_q    <= b_q << 1;
      cnt_q  <= cnt_q - CW'(1);
      run_q  <= (cnt_q != CW'(1));
      done_q <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign r    = acc_q[WIDTH-1:0];

endmodule

// File: rtl/jacob_point_double.sv
// Jacobian point doubling over GF(p): a 23-step microprogram driving one shared
// bit-serial multiplier plus inline modular add/sub.
module jacob_point_double
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flag_input,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] z3,
  output logic             flag_output,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [4:0]       step_q;
  logic             mul_pend_q, flag_q;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] p_q, x3_q, y3_q, z3_q;

  uop_t             uop;
  logic [WIDTH-1:0] opa, opb, add_r, sub_r, mul_r, wb_data;
  logic [WIDTH:0]   sum, dif;
  logic             accept, mul_start, mul_done, step_adv;

  assign uop = get_uop(step_q);
  assign opa = rf_q[uop.sa];
  assign opb = rf_q[uop.sb];

  // Results are < p, so the low WIDTH bits alone carry the reduced value.
  always_comb begin
    sum   = {1'b0, opa} + {1'b0, opb};
    add_r = sum[WIDTH-1:0] - ((sum >= {1'b0, p_q}) ? p_q : '0);
    dif   = {1'b0, opa} - {1'b0, opb};
    sub_r = dif[WIDTH-1:0] + (dif[WIDTH] ? p_q : '0);
  end

  mod_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .nrst  (nrst),
    .start (mul_start),
    .a     (opa),
    .b     (opb),
    .p     (p_q),
    .done  (mul_done),
    .r     (mul_r)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: if (step_adv && step_q == LAST_STEP) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The flag_output cycle is spent in IDLE, so a start there is masked by flag_q.
  always_comb begin
    accept    = (state_q == ST_IDLE) && flag_input && !flag_q;
    mul_start = (state_q == ST_EXEC) && (uop.op == OP_MUL) && !mul_pend_q;
    step_adv  = (state_q == ST_EXEC) && ((uop.op != OP_MUL) || mul_done);
    busy      = (state_q != ST_IDLE) || flag_q || accept;
    case (uop.op)
      OP_MUL:  wb_data = mul_r;
      OP_SUB:  wb_data = sub_r;
      default: wb_data = add_r;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rf_q       <= '{default: '0};
      p_q        <= '0;
      step_q     <= '0;
      mul_pend_q <= 1'b0;
      flag_q     <= 1'b0;
      x3_q       <= '0;
      y3_q       <= '0;
      z3_q       <= '0;
    end else begin
      flag_q <= (state_q == ST_DONE);
      if (accept) begin
        rf_q[R_X]  <= x;
        rf_q[R_Y]  <= y;
        rf_q[R_Z]  <= z;
        rf_q[R_A]  <= a;
        p_q        <= p;
        step_q     <= '0;
        mul_pend_q <= 1'b0;
      end
      if (mul_start) mul_pend_q <= 1'b1;
      if (mul_done)  mul_pend_q <= 1'b0;
      if (step_adv) begin
        rf_q[uop.dst] <= wb_data;
        step_q        <= step_q + 5'd1;
      end
      if (state_q == ST_DONE) begin
        x3_q   <= rf_q[R_X3];
        y3_q   <= rf_q[R_Y3];
        z3_q   <= rf_q[R_Z3];
        step_q <= '0;
      end
    end
  end

  assign x3          = x3_q;
  assign y3          = y3_q;
  assign z3          = z3_q;
  assign flag_output = flag_q;

endmodule

// File: tb/tb_jacob_point_double.sv
// Directed bench for jacob_point_double: small-prime vectors with hand-computed
// results, latency/busy/restart/abort checks, and one wide-prime vector.
module tb_jacob_point_double;

  localparam int unsigned W   = 256;
  localparam int          LAT = 10 * W + 35;

  logic         clk = 1'b0;
  logic         nrst, flag_input, flag_output, busy;
  logic [W-1:0] x, y, z, a, p, x3, y3, z3;

  int ncmp  = 0;
  int nfail = 0;
  int lat;
  int nflags;
  logic [W-1:0] bp, ba, bx, by, bz, ex3, ey3, ez3, ax, ay;

  always #5 clk = ~clk;

  jacob_point_double #(.WIDTH(W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .flag_input  (flag_input),
    .x           (x),
    .y           (y),
    .z           (z),
    .a           (a),
    .p           (p),
    .x3          (x3),
    .y3          (y3),
    .z3          (z3),
    .flag_output (flag_output),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mm(input logic [W-1:0] u, input logic [W-1:0] v,
                                      input logic [W-1:0] m);
    logic [2*W-1:0] t;
    t = ({{W{1'b0}}, u} * {{W{1'b0}}, v}) % {{W{1'b0}}, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] ma(input logic [W-1:0] u, input logic [W-1:0] v,
                                      input logic [W-1:0] m);
    logic [W:0] t;
    t = ({1'b0, u} + {1'b0, v}) % {1'b0, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] ms(input logic [W-1:0] u, input logic [W-1:0] v,
                                      input logic [W-1:0] m);
    logic [W:0] t;
    t = ({1'b0, u} + {1'b0, m} - {1'b0, v}) % {1'b0, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] minv(input logic [W-1:0] v, input logic [W-1:0] m);
    logic [W-1:0] e, r, b;
    e = m - 2;
    r = 1;
    b = v;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = mm(r, b, m);
      b = mm(b, b, m);
    end
    return r;
  endfunction

  // Called at a negedge: present operands and raise the start level.
  task automatic launch(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic [W-1:0] zi,
                        input logic [W-1:0] ai, input logic [W-1:0] pi);
    x = xi; y = yi; z = zi; a = ai; p = pi;
    flag_input = 1'b1;
    #1;
    check1("busy_capture", busy, 1'b1);
  endtask

  // Counts cycles from the capture cycle (0) to flag_output, checking busy on
  // the way; guard_cyc injects a one-cycle start pulse, rearm restarts at once.
  task automatic run(input string tag, input int guard_cyc, input bit rearm, output int latency);
    int cyc = 0;
    int bad = 0;
    bit seen = 1'b0;
    latency = -1;
    while (!seen && cyc < LAT + 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      flag_input = (cyc == guard_cyc);
      if (busy !== 1'b1) bad++;
      if (flag_output === 1'b1) begin
        seen = 1'b1;
        latency = cyc;
      end
    end
    check({tag, "_latency"}, W'(latency), W'(LAT));
    check({tag, "_busy_gaps"}, W'(bad), '0);
    if (rearm) begin
      flag_input = 1'b1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      check1({tag, "_busy_after"}, busy, 1'b0);
      check1({tag, "_flag_after"}, flag_output, 1'b0);
    end
  endtask

  initial begin
    nrst = 1'b0;
    flag_input = 1'b0;
    x = '0; y = '0; z = '0; a = '0; p = '0;
    repeat (3) @(negedge clk);
    check("rst_x3", x3, '0);
    check("rst_y3", y3, '0);
    check("rst_z3", z3, '0);
    check1("rst_flag", flag_output, 1'b0);
    check1("rst_busy", busy, 1'b0);
    nrst = 1'b1;
    @(negedge clk);

    launch(2, 6, 1, 4, 29);
    run("basic", -1, 1'b0, lat);
    check("basic_x3", x3, 28);
    check("basic_y3", y3, 27);
    check("basic_z3", z3, 12);

    launch(1, 1, 0, 4, 29);
    run("inf", -1, 1'b0, lat);
    check("inf_x3", x3, 1);
    check("inf_y3", y3, 1);
    check("inf_z3", z3, 0);

    launch(5, 0, 1, 4, 29);
    run("y0", -1, 1'b0, lat);
    check("y0_x3", x3, 6);
    check("y0_y3", y3, 19);
    check("y0_z3", z3, 0);

    // Stray start at cycle 100 must be ignored; a start held from the flag
    // cycle into the following one launches exactly one new run.
    launch(2, 6, 1, 4, 29);
    run("guard", 100, 1'b1, lat);
    check("guard_x3", x3, 28);
    check("guard_y3", y3, 27);
    check("guard_z3", z3, 12);
    @(posedge clk);
    @(negedge clk);
    check1("restart_flag_low", flag_output, 1'b0);
    check1("restart_busy", busy, 1'b1);
    run("restart", -1, 1'b0, lat);
    check("restart_x3", x3, 28);
    check("restart_y3", y3, 27);
    check("restart_z3", z3, 12);

    launch(5, 0, 1, 4, 29);
    @(posedge clk);
    @(negedge clk);
    flag_input = 1'b0;
    repeat (999) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("abort_x3", x3, '0);
    check("abort_y3", y3, '0);
    check("abort_z3", z3, '0);
    check1("abort_busy", busy, 1'b0);
    check1("abort_flag", flag_output, 1'b0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    nflags = 0;
    repeat (LAT + 50) begin
      @(negedge clk);
      if (flag_output === 1'b1) nflags++;
    end
    check("abort_no_flag", W'(nflags), '0);

    launch(2, 6, 1, 4, 29);
    run("fresh", -1, 1'b0, lat);
    check("fresh_x3", x3, 28);
    check("fresh_y3", y3, 27);
    check("fresh_z3", z3, 12);

    ax = mm(x3, mm(minv(z3, 29), minv(z3, 29), 29), 29);
    ay = mm(y3, minv(mm(z3, mm(z3, z3, 29), 29), 29), 29);
    check("affine_x", ax, 1);
    check("affine_y", ay, 5);

    bp = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    ba = 256'h2aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa984914a144;
    bx = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
    by = 256'h5a5a5a5a12345678deadbeefcafebabe0badf00d7777777711112222333344ff;
    bz = 256'h3c3c3c3c99999999aaaaaaaabbbbbbbb00000001fedcba987654321012345678;
    ex3 = ma(ma(mm(bx, bx, bp), mm(bx, bx, bp), bp), mm(bx, bx, bp), bp);
    ex3 = ma(ex3, mm(ba, mm(mm(bz, bz, bp), mm(bz, bz, bp), bp), bp), bp);
    ez3 = mm(4, mm(bx, mm(by, by, bp), bp), bp);
    ey3 = ms(mm(ex3, ex3, bp), ma(ez3, ez3, bp), bp);
    ey3 = ms(mm(ex3, ms(ez3, ey3, bp), bp), mm(8, mm(mm(by, by, bp), mm(by, by, bp), bp), bp), bp);
    ax  = ms(mm(ex3, ex3, bp), ma(ez3, ez3, bp), bp);
    ez3 = ma(mm(by, bz, bp), mm(by, bz, bp), bp);

    launch(bx, by, bz, ba, bp);
    run("wide", -1, 1'b0, lat);
    check("wide_x3", x3, ax);
    check("wide_y3", y3, ey3);
    check("wide_z3", z3, ez3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/jacob_point_double.md
Name: jacob_point_double

Overview:
- Doubles an elliptic-curve point in Jacobian coordinates over GF(p), curve y^2 = x^3 + a*x + b.
- Sits directly upstream of the Jacobian-to-affine converter. Its x3/y3/z3/flag_output drive that block's x3/y3/z3/flag_input unchanged.
- Uses one shared bit-serial modular multiplier, sequenced by a fixed microprogram of 23 steps.

Parameters:
- WIDTH, 256, operand width in bits; p < 2^(WIDTH-1).

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- flag_input  input  1  start pulse; x/y/z/a/p are sampled when it is seen high in IDLE
- x  input  WIDTH  Jacobian X, < p
- y  input  WIDTH  Jacobian Y, < p
- z  input  WIDTH  Jacobian Z, < p
- a  input  WIDTH  curve coefficient a, < p
- p  input  WIDTH  odd prime modulus, > 3
- x3  output  WIDTH  result X, registered
- y3  output  WIDTH  result Y, registered
- z3  output  WIDTH  result Z, registered
- flag_output  output  1  one-cycle pulse when x3/y3/z3 are valid
- busy  output  1  high from the capture cycle until the flag_output cycle, inclusive

Behaviour:
- Reset (nrst low, asynchronous): x3=y3=z3=0, flag_output=0, busy=0, FSM to IDLE, all temporaries cleared.
- Reset mid-operation aborts the operation; no flag_output is produced.
- FSM states:
  - IDLE: on flag_input=1, capture x, y, z, a, p into internal registers, go to EXEC.
  - EXEC: run steps 1..23 in order.
  - DONE: load x3/y3/z3, pulse flag_output, return to IDLE.
- flag_input is ignored in EXEC and DONE; it is level-sampled only in IDLE.
- Formulas:
  - M = 3X^2 + aZ^4
  - S = 4XY^2
  - X3 = M^2 - 2S
  - Y3 = M(S - X3) - 8Y^4
  - Z3 = 2YZ
- Microprogram (MUL = modular multiply, ADD/SUB = modular add/subtract):
  - 1 T1=X*X
  - 2 T2=Z*Z
  - 3 T2=T2*T2
  - 4 T2=a*T2
  - 5 T3=T1+T1
  - 6 T3=T3+T1
  - 7 M=T3+T2
  - 8 T4=Y*Y
  - 9 T5=X*T4
  - 10 T5=T5+T5
  - 11 S=T5+T5
  - 12 T6=M*M
  - 13 T6=T6-S
  - 14 X3=T6-S
  - 15 T7=T4*T4
  - 16-18 T7=T7+T7, three times
  - 19 T8=S-X3
  - 20 T8=M*T8
  - 21 Y3=T8-T7
  - 22 Z3=Y*Z
  - 23 Z3=Z3+Z3
- Step costs:
  - MUL step occupies exactly WIDTH+2 cycles: issue, WIDTH iterations, writeback.
  - ADD/SUB step occupies exactly 1 cycle.
- Latency: the capture cycle is cycle 0; flag_output is high in cycle 10*WIDTH+35 (2595 for WIDTH=256). busy falls in the following cycle.
- A new flag_input is accepted in the cycle after flag_output.
- Modular add: s=a+b computed in WIDTH+1 bits; if s>=p then s-=p.
- Modular sub: d=a-b; if it borrows, d+=p.
- Modular mul: MSB-first interleaved. For each bit, acc = 2*acc + bit*a; subtract p up to twice so acc < p. acc is WIDTH+2 bits internally.
- All results are fully reduced, in [0, p).
- Point at infinity (z=0) or y=0 needs no special casing: the formulas give z3=0, reported normally with the same latency.
- x3/y3/z3 hold their value until the next DONE or reset.

Decomposition:
- Shared package (ecc_pkg), holding:
  - WIDTH default
  - microprogram opcode encoding (OP_MUL, OP_ADD, OP_SUB)
  - register-select constants for X, Y, Z, a, T1..T8, M, S
  - step count 23
- Sub-module mod_mul:
  - ports: clk, nrst, start, a, b, p, done, r
  - fixed WIDTH+1 cycles from start to done
  - reused by the converter's future inversion datapath
- Modular add/sub stays inline.

Test Plan:
- Basic double: WIDTH=256, p=29, a=4, (x,y,z)=(2,6,1) -> x3=28, y3=27, z3=12, flag_output exactly at cycle 2595 after capture, busy high cycles 0..2595.
- Infinity: p=29, a=4, (1,1,0) -> z3=0, x3=1, y3=1, same latency.
- y=0: p=29, a=4, (5,0,1) -> x3=6, y3=19, z3=0.
- Busy guard: flag_input pulse at cycle 100 of an operation is ignored (a single flag_output). A pulse in the cycle after flag_output starts a second run: (2,6,1) again gives (28,27,12).
- Reset abort: nrst low at cycle 1000 -> outputs 0 immediately, no flag_output. After release, a fresh (2,6,1) run gives the correct result.
- Chained: feed outputs to the Jacobian-to-affine converter with p=29 -> affine (x,y)=(1,5), i.e. 2*(2,6) on y^2=x^3+4x+20.
